// File: rtl/trace_player_pkg.sv
// -----------------------------------------------------------------------------
// trace_player_pkg
//   Shared types and constants for the trace player controller.
//   - state_e         : playback FSM states (IDLE, RUN, DONE)
//   - NUM_CH, DEPTH   : default channel count and steps per trace
//   - STEP_W, LEN_W   : step index width and playback-length width
//   - CH_A..CH_D      : bit positions of the A..D channels in a pattern word
// -----------------------------------------------------------------------------
package trace_player_pkg;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 32;
  localparam int STEP_W = $clog2(DEPTH);
  localparam int LEN_W  = STEP_W + 1;

  localparam int CH_A = 3;
  localparam int CH_B = 2;
  localparam int CH_C = 1;
  localparam int CH_D = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/trace_mem.sv
// -----------------------------------------------------------------------------
// trace_mem
//   D x W pattern register file: one write port, one registered read port,
//   asynchronous clear of every word on reset.
//   Ports:
//     clock, reset      : clock and asynchronous active-high clear
//     wr_en/wr_addr/wr_data : write port
//     rd_en             : load rd_data from rd_addr on this edge
//     rd_clr            : force rd_data to 0 on this edge (has priority)
//     rd_addr           : read address
//     rd_data           : registered read data (holds when neither strobe set)
//   A write and a read of the same word on one edge return the old word.
// -----------------------------------------------------------------------------
module trace_mem
  import trace_player_pkg::*;
#(
  parameter int W  = NUM_CH,
  parameter int D  = DEPTH,
  parameter int AW = $clog2(D)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] rows_w [D];
  logic [W-1:0] rd_data_q;

  // One clearable register per word; the row flops live in their own block.
  for (genvar gi = 0; gi < D; gi++) begin : g_row
    logic [W-1:0] row_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        row_q <= '0;
      end else if (wr_en && (wr_addr == AW'(gi))) begin
        row_q <= wr_data;
      end
    end
    assign rows_w[gi] = row_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_clr) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= rows_w[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/trace_player_ctrl.sv
// -----------------------------------------------------------------------------
// trace_player_ctrl
//   Plays a loadable NUM_CH x DEPTH pattern out one step per clock on A..D.
//   Ports:
//     clock, reset          : clock, asynchronous active-high reset
//     wr_en/wr_addr/wr_data : pattern write (bit3=A, bit2=B, bit1=C, bit0=D)
//     len                   : playback length, sampled on an accepted start
//     start, stop           : single-cycle start / abort requests
//     loop                  : wrap-around enable (only with TRACE_PLAYER_LOOP_EN)
//     A, B, C, D            : registered trace outputs
//     step                  : index of the step currently on A..D
//     busy, done            : registered RUN / DONE indicators
//   Optional feature macro: TRACE_PLAYER_LOOP_EN (adds the loop port; with
//   loop=1 playback wraps to step 0 instead of ending in DONE).
//
//   DONE is entered on the same edge that presents the last step, so done
//   rises together with step L-1 (done=1 from cycle k+L for a start at k).
// -----------------------------------------------------------------------------
module trace_player_ctrl #(
  parameter int NUM_CH = trace_player_pkg::NUM_CH,
  parameter int DEPTH  = trace_player_pkg::DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [NUM_CH-1:0]          wr_data,
  input  logic [$clog2(DEPTH):0]     len,
  input  logic                       start,
  input  logic                       stop,
`ifdef TRACE_PLAYER_LOOP_EN
  input  logic                       loop,
`endif
  output logic                       A,
  output logic                       B,
  output logic                       C,
  output logic                       D,
  output logic [$clog2(DEPTH)-1:0]   step,
  output logic                       busy,
  output logic                       done
);
  import trace_player_pkg::*;

  localparam int SW = $clog2(DEPTH);
  localparam int LW = SW + 1;

  state_e        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [LW-1:0] len_q, len_d;
  logic          busy_q, done_q;

  logic          loop_w;
  logic          rd_en, rd_clr;
  logic [SW-1:0] rd_addr;
  logic [NUM_CH-1:0] rd_data;

  logic          accept;
  logic [LW-1:0] len_clamped;
  logic [LW-1:0] step_ext;
  logic          at_last;
  logic          next_is_last;

`ifdef TRACE_PLAYER_LOOP_EN
  assign loop_w = loop;
`else
  assign loop_w = 1'b0;
`endif

  assign accept   = start && !stop && (state_q != RUN);
  assign step_ext = {1'b0, step_q};
  // Compare in the wider length domain so L = DEPTH needs no special case.
  assign at_last      = ((step_ext + LW'(1)) == len_q);
  assign next_is_last = ((step_ext + LW'(2)) == len_q);

  always_comb begin
    len_clamped = len;
    if (len == '0) begin
      len_clamped = LW'(1);
    end else if (len > LW'(DEPTH)) begin
      len_clamped = LW'(DEPTH);
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    rd_en   = 1'b0;
    rd_clr  = 1'b0;

    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
      step_d  = '0;
      rd_clr  = 1'b1;
    end else if (accept) begin
      len_d   = len_clamped;
      step_d  = '0;
      rd_en   = 1'b1;
      state_d = ((len_clamped == LW'(1)) && !loop_w) ? DONE : RUN;
    end else begin
      case (state_q)
        IDLE: rd_clr = 1'b1;
        RUN: begin
          if (at_last) begin
            // Only reachable while looping: either wrap or settle in DONE.
            if (loop_w) begin
              step_d = '0;
              rd_en  = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            step_d = step_q + SW'(1);
            rd_en  = 1'b1;
            if (next_is_last && !loop_w) begin
              state_d = DONE;
            end
          end
        end
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  assign rd_addr = step_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      len_q   <= LW'(DEPTH);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  // The memory's registered read port doubles as the A..D output register.
  trace_mem #(
    .W (NUM_CH),
    .D (DEPTH),
    .AW(SW)
  ) u_mem (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (rd_en),
    .rd_clr (rd_clr),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign A    = rd_data[CH_A];
  assign B    = rd_data[CH_B];
  assign C    = rd_data[CH_C];
  assign D    = rd_data[CH_D];
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_trace_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trace_player_ctrl
//   Bench for trace_player_ctrl. A behavioural model predicts the output
//   vector {A,B,C,D,step,busy,done} after every clock edge and queues it; a
//   monitor on the falling edge pops and compares. Directed scenarios come
//   first, then randomized traffic. Build with TRACE_PLAYER_LOOP_EN to
//   exercise the loop port.
// -----------------------------------------------------------------------------
module tb_trace_player_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [5:0] len = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_in = 1'b0;
  logic       A, B, C, D, busy, done;
  logic [4:0] step;

  always #5 clock = ~clock;

  trace_player_ctrl dut (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .len    (len),
    .start  (start),
    .stop   (stop),
`ifdef TRACE_PLAYER_LOOP_EN
    .loop   (loop_in),
`endif
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .step   (step),
    .busy   (busy),
    .done   (done)
  );

  // ---------------- scoreboard / counters ----------------
  logic [10:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int cycle_no = 0;

  function automatic logic [10:0] actual_vec();
    return {A, B, C, D, step, busy, done};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s cycle %0d: got ABCD=%b step=%0d busy=%b done=%b, want ABCD=%b step=%0d busy=%b done=%b",
                  name, cycle_no, act[10:7], act[6:2], act[1], act[0],
                  req[10:7], req[6:2], req[1], req[0]);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) check("out", actual_vec(), exp_q.pop_front());
  end

  // ---------------- reference model ----------------
  logic [3:0] m_mem [32];
  bit         m_play;    // a playback was accepted and not stopped
  bit         m_fin;     // playback has reached its final step
  int         m_t;       // current step index
  int         m_L;       // latched length
  logic [3:0] m_disp;

  function automatic logic [10:0] model_vec();
    return {m_disp, 5'(m_t), m_play && !m_fin, m_fin};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_play = 0; m_fin = 0; m_t = 0; m_L = 32; m_disp = '0;
  endtask

  task automatic model_edge(input bit we, input int wa, input logic [3:0] wd,
                            input bit st, input bit sp, input int ln, input bit lp);
    if (sp && m_play) begin
      m_play = 0; m_fin = 0; m_t = 0; m_disp = '0;
    end else if (st && !sp && (!m_play || m_fin)) begin
      m_L    = (ln == 0) ? 1 : ((ln > 32) ? 32 : ln);
      m_play = 1;
      m_t    = 0;
      m_disp = m_mem[0];
      m_fin  = (m_L == 1) && !lp;
    end else if (m_play && !m_fin) begin
      if (m_t == m_L - 1) begin
        if (lp) begin m_t = 0; m_disp = m_mem[0]; end
        else m_fin = 1;
      end else begin
        m_t++;
        m_disp = m_mem[m_t];
        m_fin  = (m_t == m_L - 1) && !lp;
      end
    end
    if (we) m_mem[wa] = wd;   // read-before-write: the step above saw old data
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit we, input logic [4:0] wa, input logic [3:0] wd,
                             input bit st, input bit sp, input logic [5:0] ln, input bit rs);
    wr_en = we; wr_addr = wa; wr_data = wd; start = st; stop = sp; len = ln;
    @(posedge clock);
    cycle_no++;
    #1;
    if (st || sp)
      $display("cycle %0d: start=%b stop=%b len=%0d loop=%b", cycle_no, st, sp, ln, loop_in);
    if (rs) begin
      reset = 1'b1;
      #1;
      check("reset_async", actual_vec(), 11'd0);
      model_reset();
      reset = 1'b0;
      $display("cycle %0d: reset pulse", cycle_no);
    end else begin
      model_edge(we, int'(wa), wd, st, sp, int'(ln), loop_in);
    end
    exp_q.push_back(model_vec());
    wr_en = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 5'd0, 4'd0, 0, 0, 6'd0, 0);
  endtask

  task automatic write_word(input int a, input logic [3:0] d);
    drive_cycle(1, 5'(a), d, 0, 0, 6'd0, 0);
  endtask

  task automatic do_start(input int l);
    drive_cycle(0, 5'd0, 4'd0, 1, 0, 6'(l), 0);
  endtask

  initial begin
    logic [3:0] pat;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.push_back(model_vec());  // reset state seen at the next falling edge

    // Pattern A=steps1-3, B=steps1-4, C=step5, full length.
    for (int s = 0; s < 32; s++) begin
      pat = {(s >= 1 && s <= 3), (s >= 1 && s <= 4), (s == 5), 1'b0};
      write_word(s, pat);
    end
    do_start(32);
    idle(36);

    // Length 4 with D on step 3 only; restart from DONE.
    for (int s = 0; s < 32; s++) write_word(s, (s == 3) ? 4'b0001 : 4'b0000);
    do_start(4);
    idle(6);
    do_start(4);
    idle(6);

    // Stop two cycles after start; start together with stop is ignored.
    do_start(32);
    idle(1);
    drive_cycle(0, 5'd0, 4'd0, 0, 1, 6'd0, 0);
    idle(2);
    drive_cycle(0, 5'd0, 4'd0, 1, 1, 6'd8, 0);
    idle(2);

    // Length clamping.
    write_word(0, 4'b1010);
    do_start(0);
    idle(3);
    do_start(40);
    idle(34);

    // Same-edge write to the step being read returns the old word.
    write_word(2, 4'b0101);
    do_start(5);
    idle(1);
    write_word(2, 4'b1010);   // lands on the edge that reads step 2
    idle(4);
    do_start(5);
    idle(6);

`ifdef TRACE_PLAYER_LOOP_EN
    loop_in = 1'b1;
    do_start(3);
    idle(10);
    loop_in = 1'b0;
    idle(5);
`endif

    // Reset mid-run clears memory; the next playback is all zeros.
    for (int s = 0; s < 8; s++) write_word(s, 4'b1111);
    do_start(8);
    idle(3);
    drive_cycle(0, 5'd0, 4'd0, 0, 0, 6'd0, 1);
    do_start(8);
    idle(10);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] ln;
      case ($urandom % 4)
        0:       ln = 6'($urandom_range(0, 5));
        1:       ln = 6'($urandom_range(30, 40));
        2:       ln = 6'($urandom);
        default: ln = 6'd32;
      endcase
`ifdef TRACE_PLAYER_LOOP_EN
      if ($urandom % 50 == 0) loop_in = ~loop_in;
`endif
      drive_cycle(($urandom % 4) == 0, 5'($urandom), 4'($urandom),
                  ($urandom % 10) == 0, ($urandom % 40) == 0, ln,
                  ($urandom % 700) == 0);
    end

    repeat (3) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
